// File: rtl/regfile_wb_sink_pkg.sv
// Shared types and sizes for the write-back register file.
// Build option: WB_BYPASS_EN enables same-cycle write-to-read bypass.
package regfile_wb_sink_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  localparam logic [AW-1:0] REG_ZERO = '0;

  typedef logic [NREG-1:0] pendVec_t;

endpackage

// File: rtl/regfile_wb_sink_scoreboard.sv
// Pending-write scoreboard: per-register busy bits and live count.
// Build option: WB_BYPASS_EN hides registers written this cycle.
module regfile_wb_sink_scoreboard
  import regfile_wb_sink_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          setEn,
  input  logic [AW-1:0] setRd,
  input  logic          clrEn,
  input  logic [AW-1:0] clrRd,
  input  logic [AW-1:0] a1,
  input  logic [AW-1:0] a2,
  output logic          pendEff1,
  output logic          pendEff2,
  output logic [AW:0]   pendCnt
);

  pendVec_t pending;
  pendVec_t pendNext;
  pendVec_t setMask;
  pendVec_t clrMask;
  logic     setV;
  logic     clrV;
  logic     inc;
  logic     dec;

  always_comb begin
    setV    = setEn && (setRd != REG_ZERO);
    clrV    = clrEn && (clrRd != REG_ZERO);
    setMask = '0;
    clrMask = '0;
    if (setV) setMask[setRd] = 1'b1;
    if (clrV) clrMask[clrRd] = 1'b1;
    // set is applied last so the younger producer wins
    pendNext = (pending & ~clrMask) | setMask;
    inc = setV && !pending[setRd];
    dec = clrV && pending[clrRd]
        && !(setV && (setRd == clrRd));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      pendCnt <= '0;
    end else begin
      pending <= pendNext;
      unique case ({inc, dec})
        2'b10:   pendCnt <= pendCnt + {{AW{1'b0}}, 1'b1};
        2'b01:   pendCnt <= pendCnt - {{AW{1'b0}}, 1'b1};
        default: pendCnt <= pendCnt;
      endcase
    end
  end

  always_comb begin
`ifdef WB_BYPASS_EN
    pendEff1 = pending[a1] && (a1 != REG_ZERO)
             && !(clrV && (clrRd == a1));
    pendEff2 = pending[a2] && (a2 != REG_ZERO)
             && !(clrV && (clrRd == a2));
`else
    pendEff1 = pending[a1] && (a1 != REG_ZERO);
    pendEff2 = pending[a2] && (a2 != REG_ZERO);
`endif
  end

endmodule

// File: rtl/regfile_wb_sink.sv
// Integer register file fed by write-back, read by decode, with stall.
// Build option: WB_BYPASS_EN forwards ResultW to same-cycle reads.
module regfile_wb_sink
  import regfile_wb_sink_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            RegwriteW,
  input  logic [AW-1:0]   RdW,
  input  logic [XLEN-1:0] ResultW,
  input  logic [AW-1:0]   A1,
  input  logic [AW-1:0]   A2,
  input  logic            Use1,
  input  logic            Use2,
  output logic [XLEN-1:0] RD1,
  output logic [XLEN-1:0] RD2,
  input  logic            SbSet,
  input  logic [AW-1:0]   SbRd,
  output logic            StallD,
  output logic [AW:0]     PendCnt
);

  logic [XLEN-1:0] regs [NREG];
  logic            wbHit;
  logic            pendEff1;
  logic            pendEff2;

  assign wbHit = RegwriteW && (RdW != REG_ZERO);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++)
        regs[i] <= '0;
    end else if (wbHit) begin
      regs[RdW] <= ResultW;
    end
  end

  always_comb begin
    RD1 = (A1 == REG_ZERO) ? '0 : regs[A1];
    RD2 = (A2 == REG_ZERO) ? '0 : regs[A2];
`ifdef WB_BYPASS_EN
    if (wbHit && (RdW == A1)) RD1 = ResultW;
    if (wbHit && (RdW == A2)) RD2 = ResultW;
`endif
  end

  regfile_wb_sink_scoreboard uSb (
    .clk      (clk),
    .rst      (rst),
    .setEn    (SbSet),
    .setRd    (SbRd),
    .clrEn    (RegwriteW),
    .clrRd    (RdW),
    .a1       (A1),
    .a2       (A2),
    .pendEff1 (pendEff1),
    .pendEff2 (pendEff2),
    .pendCnt  (PendCnt)
  );

  assign StallD = (Use1 && pendEff1) || (Use2 && pendEff2);

endmodule
